// File: rtl/dtu_pkg.sv
// Shared types and widths for the dtu receive-side buffer.
// The FIFO entry pairs a character with the error flag of the frame it came from.
package dtu_pkg;

    localparam int unsigned CHAR_W    = 7;
    localparam int unsigned ERR_CNT_W = 8;
    localparam int unsigned ENTRY_W   = CHAR_W + 1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PUSH1    = 3'd1,
        PUSH2    = 3'd2,
        ACK      = 3'd3,
        WAIT_CLR = 3'd4
    } rx_buf_state_t;

    typedef struct packed {
        logic              err;
        logic [CHAR_W-1:0] ch;
    } rx_entry_t;

    // A frame is two characters, so capture needs at least two free slots.
    function automatic logic frame_fits(input int unsigned occupancy, input int unsigned depth);
        return (occupancy + 2) <= depth;
    endfunction

endpackage

// File: rtl/char_fifo.sv
// Synchronous first-word-fall-through FIFO; occupancy counter drives full/empty.
// The head word is visible combinationally, and reads 0 while the FIFO is empty.
module char_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3,
    parameter int unsigned W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         empty,
    output logic         full,
    output logic [AW:0]  count
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));
    assign pop   = rd_en && !empty;
    assign push  = wr_en && (!full || pop);

    assign rd_data = empty ? '0 : mem[rd_ptr];

    // Storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dtu_rx_buffer.sv
// Drains dtu receiver frames into a character FIFO via the rx_ready/rx_ack handshake.
// Owns the capture FSM, the acknowledge pulse and the saturating error counter.
module dtu_rx_buffer
    import dtu_pkg::*;
#(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned AW       = 3,
    parameter bit          DROP_ERR = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 rx_ready,
    input  logic                 rx_error,
    input  logic [CHAR_W-1:0]    rx_character1,
    input  logic [CHAR_W-1:0]    rx_character2,
    output logic                 rx_ack,
    input  logic                 rd_en,
    output logic [CHAR_W-1:0]    rd_data,
    output logic                 rd_err,
    output logic                 empty,
    output logic                 full,
    output logic [AW:0]          count,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    rx_buf_state_t state;
    rx_buf_state_t state_next;
    logic          wr_en_c;
    rx_entry_t     wr_entry_c;
    logic          err_inc_c;
    rx_entry_t     head;
    logic          room;

    assign room = frame_fits(32'(count), DEPTH);

    char_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en_c),
        .wr_data (wr_entry_c),
        .rd_en   (rd_en),
        .rd_data (head),
        .empty   (empty),
        .full    (full),
        .count   (count)
    );

    assign rd_data = head.ch;
    assign rd_err  = head.err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and FIFO write control; characters are written straight from the held inputs.
    always_comb begin
        state_next = state;
        wr_en_c    = 1'b0;
        wr_entry_c = '0;
        err_inc_c  = 1'b0;
        case (state)
            IDLE: begin
                if (en && rx_ready) begin
                    if (DROP_ERR && rx_error) begin
                        state_next = ACK;
                        err_inc_c  = 1'b1;
                    end else if (room) begin
                        state_next = PUSH1;
                    end
                end
            end
            PUSH1: begin
                wr_en_c    = 1'b1;
                wr_entry_c = '{err: rx_error, ch: rx_character1};
                state_next = PUSH2;
            end
            PUSH2: begin
                wr_en_c    = 1'b1;
                wr_entry_c = '{err: rx_error, ch: rx_character2};
                err_inc_c  = rx_error;
                state_next = ACK;
            end
            ACK: begin
                state_next = WAIT_CLR;
            end
            WAIT_CLR: begin
                if (!rx_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // rx_ack is registered so it is high exactly while the FSM sits in ACK.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_ack <= 1'b0;
        end else begin
            rx_ack <= (state_next == ACK);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (err_inc_c && (err_cnt != {ERR_CNT_W{1'b1}})) begin
            err_cnt <= err_cnt + ERR_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_dtu_rx_buffer.sv
// Directed bench for dtu_rx_buffer: one instance storing errored frames, one dropping them.
module tb_dtu_rx_buffer;

    logic       clk;
    logic       rst;
    logic       en;
    logic       rx_ready;
    logic       rx_error;
    logic [6:0] ch1;
    logic [6:0] ch2;
    logic       rx_ack;
    logic       rd_en;
    logic [6:0] rd_data;
    logic       rd_err;
    logic       empty;
    logic       full;
    logic [3:0] count;
    logic [7:0] err_cnt;

    logic       d_en;
    logic       d_rx_ready;
    logic       d_rx_error;
    logic [6:0] d_ch1;
    logic [6:0] d_ch2;
    logic       d_rx_ack;
    logic       d_rd_en;
    logic [6:0] d_rd_data;
    logic       d_rd_err;
    logic       d_empty;
    logic       d_full;
    logic [3:0] d_count;
    logic [7:0] d_err_cnt;

    int errors = 0;
    int checks = 0;
    int acks;

    dtu_rx_buffer #(.DEPTH(8), .AW(3), .DROP_ERR(1'b0)) dut (
        .clk(clk), .rst(rst), .en(en), .rx_ready(rx_ready), .rx_error(rx_error),
        .rx_character1(ch1), .rx_character2(ch2), .rx_ack(rx_ack), .rd_en(rd_en),
        .rd_data(rd_data), .rd_err(rd_err), .empty(empty), .full(full),
        .count(count), .err_cnt(err_cnt)
    );

    dtu_rx_buffer #(.DEPTH(8), .AW(3), .DROP_ERR(1'b1)) dut_drop (
        .clk(clk), .rst(rst), .en(d_en), .rx_ready(d_rx_ready), .rx_error(d_rx_error),
        .rx_character1(d_ch1), .rx_character2(d_ch2), .rx_ack(d_rx_ack), .rd_en(d_rd_en),
        .rd_data(d_rd_data), .rd_err(d_rd_err), .empty(d_empty), .full(d_full),
        .count(d_count), .err_cnt(d_err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a frame, hold rx_ready for a fixed window counting ack pulses, then release.
    task automatic send_frame(input logic [6:0] c1, input logic [6:0] c2, input logic er,
                              input int window, output int n_ack);
        ch1 = c1; ch2 = c2; rx_error = er; rx_ready = 1'b1;
        n_ack = 0;
        for (int i = 0; i < window; i++) begin
            @(negedge clk);
            if (rx_ack) n_ack++;
        end
        rx_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic pop_check(input string tag, input logic [6:0] exp_d, input logic exp_e);
        chk(tag, 32'(rd_data), 32'(exp_d));
        chk({tag, "_err"}, 32'(rd_err), 32'(exp_e));
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; rx_ready = 1'b0; rx_error = 1'b0; ch1 = '0; ch2 = '0; rd_en = 1'b0;
        d_en = 1'b1; d_rx_ready = 1'b0; d_rx_error = 1'b0; d_ch1 = '0; d_ch2 = '0; d_rd_en = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_ack", 32'(rx_ack), 0);
        chk("rst_errcnt", 32'(err_cnt), 0);
        chk("rst_rdata", 32'(rd_data), 0);
        chk("rst_rderr", 32'(rd_err), 0);
        rst = 1'b0;
        @(negedge clk);

        // Single clean frame, then read it back.
        send_frame(7'h41, 7'h42, 1'b0, 6, acks);
        chk("t1_acks", 32'(acks), 1);
        chk("t1_count", 32'(count), 2);
        pop_check("t1_rd0", 7'h41, 1'b0);
        pop_check("t1_rd1", 7'h42, 1'b0);
        chk("t1_empty", 32'(empty), 1);
        chk("t1_count0", 32'(count), 0);

        // rx_ready held long after ack must not recapture.
        send_frame(7'h43, 7'h44, 1'b0, 25, acks);
        chk("t2_acks", 32'(acks), 1);
        chk("t2_count", 32'(count), 2);
        pop_check("t2_rd0", 7'h43, 1'b0);
        pop_check("t2_rd1", 7'h44, 1'b0);

        // Fill to full, then backpressure a fifth frame.
        for (int i = 0; i < 4; i++) begin
            send_frame(7'(8'h50 + 2*i), 7'(8'h51 + 2*i), 1'b0, 6, acks);
            chk("t3_fill_ack", 32'(acks), 1);
        end
        chk("t3_full", 32'(full), 1);
        chk("t3_count8", 32'(count), 8);
        ch1 = 7'h60; ch2 = 7'h61; rx_error = 1'b0; rx_ready = 1'b1;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rx_ack) acks++;
        end
        chk("t3_noack_full", 32'(acks), 0);
        pop_check("t3_pop0", 7'h50, 1'b0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rx_ack) acks++;
        end
        chk("t3_noack_1slot", 32'(acks), 0);
        chk("t3_count7", 32'(count), 7);
        pop_check("t3_pop1", 7'h51, 1'b0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rx_ack) acks++;
        end
        chk("t3_ack_2slot", 32'(acks), 1);
        chk("t3_count_after", 32'(count), 8);
        rx_ready = 1'b0;
        @(negedge clk);
        for (int i = 2; i < 8; i++) pop_check("t3_drain", 7'(8'h50 + i), 1'b0);
        pop_check("t3_drain5a", 7'h60, 1'b0);
        pop_check("t3_drain5b", 7'h61, 1'b0);
        chk("t3_empty", 32'(empty), 1);

        // Errored frame stored with tag.
        send_frame(7'h10, 7'h11, 1'b1, 6, acks);
        chk("t4_acks", 32'(acks), 1);
        chk("t4_errcnt", 32'(err_cnt), 1);
        pop_check("t4_rd0", 7'h10, 1'b1);
        pop_check("t4_rd1", 7'h11, 1'b1);

        // Errored frame dropped: acked the cycle after sampling, nothing stored.
        d_ch1 = 7'h10; d_ch2 = 7'h11; d_rx_error = 1'b1; d_rx_ready = 1'b1;
        @(negedge clk);
        chk("t4d_ack", 32'(d_rx_ack), 1);
        @(negedge clk);
        chk("t4d_ack_low", 32'(d_rx_ack), 0);
        d_rx_ready = 1'b0;
        @(negedge clk);
        chk("t4d_count", 32'(d_count), 0);
        chk("t4d_empty", 32'(d_empty), 1);
        chk("t4d_errcnt", 32'(d_err_cnt), 1);
        d_ch1 = 7'h20; d_ch2 = 7'h21; d_rx_error = 1'b0; d_rx_ready = 1'b1;
        repeat (5) @(negedge clk);
        d_rx_ready = 1'b0;
        @(negedge clk);
        chk("t4d_clean_count", 32'(d_count), 2);
        chk("t4d_clean_head", 32'(d_rd_data), 32'h20);
        d_rx_error = 1'b1;
        for (int i = 0; i < 260; i++) begin
            d_rx_ready = 1'b1;
            repeat (2) @(negedge clk);
            d_rx_ready = 1'b0;
            @(negedge clk);
        end
        chk("t4d_errcnt_sat", 32'(d_err_cnt), 255);

        // Pop coinciding with the PUSH2 write.
        send_frame(7'h30, 7'h31, 1'b0, 6, acks);
        ch1 = 7'h32; ch2 = 7'h33; rx_error = 1'b0; rx_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t5_count_push2", 32'(count), 3);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        chk("t5_ack", 32'(rx_ack), 1);
        chk("t5_count_after", 32'(count), 3);
        @(negedge clk);
        rx_ready = 1'b0;
        @(negedge clk);
        pop_check("t5_rd0", 7'h31, 1'b0);
        pop_check("t5_rd1", 7'h32, 1'b0);
        pop_check("t5_rd2", 7'h33, 1'b0);
        for (int i = 0; i < 12; i++) begin
            send_frame(7'(2*i + 1), 7'(2*i + 2), 1'b0, 6, acks);
            chk("t5_wrap_ack", 32'(acks), 1);
            pop_check("t5_wrap_a", 7'(2*i + 1), 1'b0);
            pop_check("t5_wrap_b", 7'(2*i + 2), 1'b0);
        end
        chk("t5_wrap_empty", 32'(empty), 1);

        // Reset during PUSH1 with a frame already buffered.
        send_frame(7'h70, 7'h71, 1'b0, 6, acks);
        chk("t6_pre_count", 32'(count), 2);
        ch1 = 7'h72; ch2 = 7'h73; rx_error = 1'b0; rx_ready = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t6_rst_count", 32'(count), 0);
        chk("t6_rst_empty", 32'(empty), 1);
        chk("t6_rst_ack", 32'(rx_ack), 0);
        @(negedge clk);
        chk("t6_rst_ack2", 32'(rx_ack), 0);
        rst = 1'b0;
        acks = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rx_ack) acks++;
        end
        chk("t6_recap_acks", 32'(acks), 1);
        chk("t6_recap_count", 32'(count), 2);
        rx_ready = 1'b0;
        @(negedge clk);
        pop_check("t6_rd0", 7'h72, 1'b0);
        pop_check("t6_rd1", 7'h73, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
